// File: rtl/div_gen.sv
// Multi-cycle restoring radix-2 divider, signed or unsigned, with divide-by-zero
// detection, annul (flush) support and a start/ready handshake held until consumed.
module div_gen #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 div_zero_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {FREE, BYZERO, ON, FIX, END} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 neg1_q, neg1_d;
  logic                 neg2_q, neg2_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH:0]       trial;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    zero_d     = zero_q;
    result_d   = result_q;
    ready_d    = ready_q;
    div_zero_d = div_zero_q;
    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    trial      = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};

    case (state_q)
      FREE: begin
        ready_d    = 1'b0;
        result_d   = '0;
        div_zero_d = 1'b0;
        if (start_i && !annul_i) begin
          neg1_d  = signed_div_i & opdata1_i[WIDTH-1];
          neg2_d  = signed_div_i & opdata2_i[WIDTH-1];
          dvd_d   = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dvs_d   = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          rem_d   = '0;
          cnt_d   = '0;
          zero_d  = 1'b0;
          state_d = (opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          dvd_d   = '0;
          rem_d   = '0;
          zero_d  = 1'b1;
          state_d = END;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          if (neg1_q ^ neg2_q) dvd_d = -dvd_q;
          if (neg1_q)          rem_d = -rem_q;
          state_d = END;
        end
      end
      END: begin
        if (start_i) begin
          ready_d    = 1'b1;
          result_d   = {rem_q, dvd_q};
          div_zero_d = zero_q;
        end else begin
          ready_d    = 1'b0;
          result_d   = '0;
          div_zero_d = 1'b0;
          state_d    = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      zero_q     <= zero_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign div_zero_o = div_zero_q;
  assign busy_o     = (state_q != FREE);

endmodule

// File: tb/tb_div_gen.sv
// Bench for div_gen: directed vector table, random operands against an arithmetic
// reference, and handshake/annul/reset corner sequences at WIDTH=32 and WIDTH=8.
module tb_div_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        sgn, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, dz, busy;

  logic        s8, st8, an8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        rdy8, dz8, busy8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_gen #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready),
    .div_zero_o(dz), .busy_o(busy)
  );

  div_gen #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(st8), .annul_i(an8), .result_o(r8), .ready_o(rdy8),
    .div_zero_o(dz8), .busy_o(busy8)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a, b;
    logic [31:0] q, r;
    bit          dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {dz, remainder, quotient} from plain integer division of w-bit operands.
  function automatic logic [128:0] model(input int w, input bit s, input logic [63:0] a,
                                         input logic [63:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     mask, qq, rr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua = a & mask;
    ub = b & mask;
    if (ub == 0) return {1'b1, 128'd0};
    if (s) begin
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
      sq = sa / sb;
      sr = sa % sb;
      qq = sq;
      rr = sr;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      qq = uq;
      rr = ur;
    end
    return {1'b0, rr & mask, qq & mask};
  endfunction

  // Accept, scramble inputs after the accept edge, count edges until ready.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic z, output int lat);
    int n = 0;
    @(negedge clk);
    sgn = s; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    op1 = $urandom; op2 = $urandom; sgn = ~s;
    while (!ready && n < 100) begin
      @(posedge clk); n++; #1;
    end
    lat = (n >= 100) ? -1 : n;
    res = result;
    z = dz;
  endtask

  // One extra held cycle, then release start and confirm the return to idle.
  task automatic release_op(input string name, input logic [63:0] res);
    @(posedge clk); #1;
    check({name, "_hold"}, {ready, result}, {1'b1, res});
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check({name, "_idle"}, {busy, ready, dz, result}, 67'd0);
  endtask

  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output logic z, output int lat);
    int n = 0;
    @(negedge clk);
    s8 = s; a8 = a; b8 = b; st8 = 1'b1;
    @(posedge clk);
    #1;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
    while (!rdy8 && n < 100) begin
      @(posedge clk); n++; #1;
    end
    lat = (n >= 100) ? -1 : n;
    res = r8;
    z = dz8;
    @(negedge clk); st8 = 1'b0;
    @(posedge clk); #1;
    check("w8_idle", {busy8, rdy8, dz8, r8}, 19'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [63:0] res;
    logic [15:0] res8;
    logic [128:0] m;
    logic        z;
    int          lat;
    bit          seen;

    rst = 1'b0; sgn = 0; start = 0; annul = 0; op1 = '0; op2 = '0;
    s8 = 0; st8 = 0; an8 = 0; a8 = '0; b8 = '0;

    vecs.push_back('{0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 0});
    vecs.push_back('{1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 0});
    vecs.push_back('{1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 0});
    vecs.push_back('{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 0});
    vecs.push_back('{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 0});
    vecs.push_back('{0, 32'd0,          32'd5,          32'h00000000, 32'h00000000, 0});
    vecs.push_back('{0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF, 32'h0000000F, 0});
    vecs.push_back('{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 0});
    vecs.push_back('{0, 32'd5,          32'd0,          32'h00000000, 32'h00000000, 1});
    vecs.push_back('{1, 32'h80000000,   32'd0,          32'h00000000, 32'h00000000, 1});

    #3;
    check("reset_outputs", {busy, ready, dz, result, busy8, rdy8, dz8, r8}, 86'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, res, z, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), vecs[i].dz ? 64'd2 : 64'd34);
      check($sformatf("vec%0d_res", i), {z, res}, {vecs[i].dz, vecs[i].r, vecs[i].q});
      release_op($sformatf("vec%0d", i), {vecs[i].r, vecs[i].q});
    end

    for (int i = 0; i < 30; i++) begin
      bit          s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      m = model(32, s, {32'd0, a}, {32'd0, b});
      run_op(s, a, b, res, z, lat);
      check($sformatf("rnd%0d_lat", i), 64'(lat), m[128] ? 64'd2 : 64'd34);
      check($sformatf("rnd%0d_res", i), {z, res}, {m[128], m[95:64], m[31:0]});
      release_op($sformatf("rnd%0d", i), {m[95:64], m[31:0]});
    end

    // Annul partway through the iterations: no ready, back to idle.
    seen = 0;
    @(negedge clk); sgn = 0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    repeat (10) begin @(posedge clk); #1; seen |= ready; end
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("annul_on_free", {busy, ready}, 2'b00);
    @(negedge clk); annul = 1'b0;
    repeat (40) begin @(posedge clk); #1; seen |= ready; end
    check("annul_on_noready", 64'(seen), 64'd0);
    run_op(0, 32'd100, 32'd7, res, z, lat);
    check("after_annul", {z, res, 32'(lat)}, {1'b0, 32'd2, 32'd14, 32'd34});
    release_op("after_annul", {32'd2, 32'd14});

    // Annul in the divide-by-zero path.
    @(negedge clk); op1 = 32'd9; op2 = 32'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("annul_byzero", {busy, ready, dz}, 3'b000);
    @(negedge clk); annul = 1'b0;

    // Annul together with start in FREE must not accept.
    @(negedge clk); op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("annul_blocks_accept", {busy, ready}, 2'b00);
    @(negedge clk); start = 1'b0; annul = 1'b0;

    // Annul in END is ignored.
    run_op(0, 32'd50, 32'd6, res, z, lat);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    check("annul_end_ignored", {busy, ready, result}, {1'b1, 1'b1, 32'd2, 32'd8});
    @(negedge clk); annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("end_release", {busy, ready, result}, 66'd0);

    // Asynchronous reset with a result on the outputs.
    run_op(0, 32'd100, 32'd7, res, z, lat);
    #2; rst = 1'b0; #1;
    check("async_rst_end", {busy, ready, dz, result}, 67'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Asynchronous reset mid-iteration, then a clean new operation.
    @(negedge clk); op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (6) @(posedge clk);
    #3; rst = 1'b0; #1;
    check("async_rst_on", {busy, ready, result}, 66'd0);
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_op(0, 32'd100, 32'd7, res, z, lat);
    check("after_rst", {z, res, 32'(lat)}, {1'b0, 32'd2, 32'd14, 32'd34});
    release_op("after_rst", {32'd2, 32'd14});

    // WIDTH=8 instance.
    run8(0, 8'd200, 8'd3, res8, z, lat);
    check("w8_200_3", {z, res8, 32'(lat)}, {1'b0, 8'd2, 8'd66, 32'd10});
    for (int i = 0; i < 12; i++) begin
      bit         s;
      logic [7:0] a, b;
      s = 1'($urandom);
      a = 8'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      if (i == 0) begin s = 1; a = 8'h80; b = 8'hFF; end
      m = model(8, s, {56'd0, a}, {56'd0, b});
      run8(s, a, b, res8, z, lat);
      check($sformatf("w8_rnd%0d", i), {z, res8, 32'(lat)},
            {m[128], m[71:64], m[7:0], m[128] ? 32'd2 : 32'd10});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
